// File: rtl/dma_stripe_reader.sv
// Stripe reader: streams a contiguous pixel region from a 1-cycle-latency memory
// and deals consecutive pixels round-robin into NUM_CH backpressured lane FIFOs.
module dma_stripe_reader #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [ADDR_W-1:0]        base_addr_i,
    input  logic [ADDR_W-1:0]        length_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     aborted_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic                     mem_en_o,
    output logic                     mem_rw_o,
    input  logic [DATA_W-1:0]        mem_data_in_i,
    output logic [NUM_CH*DATA_W-1:0] ch_data_o,
    output logic [NUM_CH-1:0]        ch_wr_en_o,
    input  logic [NUM_CH-1:0]        ch_full_i
);
    localparam int LW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0]        base_q, base_d;
    logic [ADDR_W-1:0]        len_q, len_d;
    logic [ADDR_W-1:0]        memAddr_q, memAddr_d;
    logic                     memEn_q, memEn_d;
    logic                     done_q, done_d;
    logic                     aborted_q, aborted_d;
    logic                     abortSeen_q, abortSeen_d;
    logic [NUM_CH*DATA_W-1:0] chData_q, chData_d;
    logic [NUM_CH-1:0]        chWrEn_q, chWrEn_d;
    // Tag stage 0 tracks the memory request, 1 the returning data, 2 the lane write.
    logic [2:0]               tagV_q, tagV_d;
    logic [2:0][LW-1:0]       tagL_q, tagL_d;

    logic [LW-1:0]            lane;
    logic                     laneBusy;
    logic                     finishing;
    logic                     endAbort;
    logic                     pipeEmptyNext;

    assign lane = (NUM_CH == 1) ? '0 : idx_q[LW-1:0];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        base_d      = base_q;
        len_d       = len_q;
        memAddr_d   = memAddr_q;
        memEn_d     = 1'b0;
        done_d      = done_q;
        aborted_d   = aborted_q;
        abortSeen_d = abortSeen_q;
        chData_d    = chData_q;
        chWrEn_d    = '0;
        tagV_d      = {tagV_q[1:0], 1'b0};
        tagL_d      = {tagL_q[1], tagL_q[0], lane};
        finishing   = 1'b0;
        endAbort    = abortSeen_q | abort_i;

        laneBusy = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (tagV_q[s] && (tagL_q[s] == lane)) begin
                laneBusy = 1'b1;
            end
        end

        // Stage 2 empties at this edge, so only stages 0 and 1 can still hold work.
        pipeEmptyNext = !tagV_q[0] && !tagV_q[1];

        if (tagV_q[1]) begin
            chData_d[int'(tagL_q[1])*DATA_W +: DATA_W] = mem_data_in_i;
            chWrEn_d[tagL_q[1]] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    base_d      = base_addr_i;
                    len_d       = length_i;
                    idx_d       = '0;
                    done_d      = 1'b0;
                    aborted_d   = 1'b0;
                    abortSeen_d = 1'b0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (abort_i || (idx_q == len_q)) begin
                    finishing = 1'b1;
                end else if (!ch_full_i[lane] && !laneBusy) begin
                    memEn_d   = 1'b1;
                    memAddr_d = base_q + idx_q;
                    idx_d     = idx_q + ADDR_W'(1);
                    tagV_d[0] = 1'b1;
                end
            end
            DRAIN: begin
                finishing = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (finishing) begin
            abortSeen_d = endAbort;
            if (pipeEmptyNext) begin
                state_d   = IDLE;
                done_d    = !endAbort;
                aborted_d = endAbort;
            end else begin
                state_d = DRAIN;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            base_q      <= '0;
            len_q       <= '0;
            memAddr_q   <= '0;
            memEn_q     <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            abortSeen_q <= 1'b0;
            chData_q    <= '0;
            chWrEn_q    <= '0;
            tagV_q      <= '0;
            tagL_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            len_q       <= len_d;
            memAddr_q   <= memAddr_d;
            memEn_q     <= memEn_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            abortSeen_q <= abortSeen_d;
            chData_q    <= chData_d;
            chWrEn_q    <= chWrEn_d;
            tagV_q      <= tagV_d;
            tagL_q      <= tagL_d;
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign aborted_o  = aborted_q;
    assign mem_addr_o = memAddr_q;
    assign mem_en_o   = memEn_q;
    assign mem_rw_o   = 1'b0;
    assign ch_data_o  = chData_q;
    assign ch_wr_en_o = chWrEn_q;

endmodule
